// File: rtl/booth_controller.sv
// booth_controller: control FSM for the 8-bit radix-4 Booth multiplier.
// It loads the multiplicand into B and the multiplier into A, runs four
// add/shift iterations driven by the A[2:0] Booth triplet, aligns the
// product into C and then holds C on the x bus.
module booth_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  A_Val,
   output logic [3:0]  TransferSignals,
   output logic [2:0]  LoadSignals,
   output logic [11:0] ALU_Signals,
   output logic        ShiftLeftSignal,
   output logic        busy,
   output logic        done
);

   localparam logic [11:0] OP_NOP  = 12'h000;
   localparam logic [11:0] OP_PASS = 12'h001;
   localparam logic [11:0] OP_LDQ  = 12'h002;
   localparam logic [11:0] OP_ADD  = 12'h004;
   localparam logic [11:0] OP_SUB  = 12'h008;
   localparam logic [11:0] OP_ASR1 = 12'h010;
   localparam logic [11:0] OP_ASR2 = 12'h020;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD_M   = 3'd1,
      S_WAIT_Q = 3'd2,
      S_LD_Q   = 3'd3,
      S_ADD    = 3'd4,
      S_SHIFT  = 3'd5,
      S_FIX    = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  it_q, it_d;
   logic        start_q;
   logic        start_edge_s;

   logic [3:0]  transfer_s;
   logic [2:0]  load_s;
   logic [11:0] alu_s;
   logic        shl_s;
   logic        busy_s;
   logic        done_s;

   // A start held high yields exactly one rising edge.
   assign start_edge_s = start & ~start_q;

   // State, iteration counter and start history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         it_q    <= 2'd0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         it_q    <= it_d;
         start_q <= start;
      end
   end

   // Next-state logic and raw per-state control decode.
   always_comb begin
      state_d    = state_q;
      it_d       = it_q;
      transfer_s = 4'b0000;
      load_s     = 3'b000;
      alu_s      = OP_NOP;
      shl_s      = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_edge_s) begin
               state_d = S_LD_M;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LD_M: begin
            // B <- sign-extended SW (multiplicand)
            transfer_s = 4'b1000;
            alu_s      = OP_PASS;
            load_s     = 3'b010;
            busy_s     = 1'b1;
            state_d    = S_WAIT_Q;
         end
         S_WAIT_Q: begin
            busy_s = 1'b1;
            if (start_edge_s) begin
               state_d = S_LD_Q;
            end else begin
               state_d = S_WAIT_Q;
            end
         end
         S_LD_Q: begin
            // A <- {acc=0, multiplier, Booth bit=0}
            transfer_s = 4'b1000;
            alu_s      = OP_LDQ;
            load_s     = 3'b001;
            busy_s     = 1'b1;
            it_d       = 2'd0;
            state_d    = S_ADD;
         end
         S_ADD: begin
            // Triplet decode; a zero digit leaves A untouched so the
            // iteration still costs a fixed two cycles.
            transfer_s = 4'b0011;
            load_s     = 3'b001;
            busy_s     = 1'b1;
            case (A_Val)
               3'b001, 3'b010: begin
                  alu_s = OP_ADD;
                  shl_s = 1'b0;
               end
               3'b011: begin
                  alu_s = OP_ADD;
                  shl_s = 1'b1;
               end
               3'b100: begin
                  alu_s = OP_SUB;
                  shl_s = 1'b1;
               end
               3'b101, 3'b110: begin
                  alu_s = OP_SUB;
                  shl_s = 1'b0;
               end
               default: begin
                  // 000 / 111: zero digit
                  alu_s  = OP_NOP;
                  load_s = 3'b000;
               end
            endcase
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            transfer_s = 4'b0001;
            alu_s      = OP_ASR2;
            load_s     = 3'b001;
            busy_s     = 1'b1;
            if (it_q == 2'd3) begin
               state_d = S_FIX;
            end else begin
               it_d    = it_q + 2'd1;
               state_d = S_ADD;
            end
         end
         S_FIX: begin
            // Drop the leftover Booth bit: C <- A >>> 1 is the product.
            transfer_s = 4'b0001;
            alu_s      = OP_ASR1;
            load_s     = 3'b100;
            busy_s     = 1'b1;
            it_d       = 2'd0;
            state_d    = S_DONE;
         end
         S_DONE: begin
            transfer_s = 4'b0100;
            done_s     = 1'b1;
            if (start_edge_s) begin
               state_d = S_LD_M;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            it_d    = 2'd0;
         end
      endcase
   end

   // Output stage: everything is forced quiet while reset is asserted.
   always_comb begin
      if (reset) begin
         TransferSignals = 4'b0000;
         LoadSignals     = 3'b000;
         ALU_Signals     = OP_NOP;
         ShiftLeftSignal = 1'b0;
         busy            = 1'b0;
         done            = 1'b0;
      end else begin
         TransferSignals = transfer_s;
         LoadSignals     = load_s;
         ALU_Signals     = alu_s;
         ShiftLeftSignal = shl_s;
         busy            = busy_s;
         done            = done_s;
      end
   end

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: drives booth_controller with a small behavioural
// datapath (A, B, C registers, x/y buses, ALU) attached, and checks control
// outputs and Answer against hand-computed products.
module tb_booth_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  a_val;
   logic [3:0]  transfer;
   logic [2:0]  load;
   logic [11:0] alu;
   logic        shl;
   logic        busy;
   logic        done;

   logic [7:0]         sw;
   logic signed [31:0] reg_a, reg_b, reg_c;
   logic signed [31:0] x_bus, y_bus, z_bus;
   logic [15:0]        answer;

   int chk_cnt       = 0;
   int pass_cnt      = 0;
   int nop_load_viol = 0;

   always #5 clk = ~clk;

   booth_controller dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .A_Val           (a_val),
      .TransferSignals (transfer),
      .LoadSignals     (load),
      .ALU_Signals     (alu),
      .ShiftLeftSignal (shl),
      .busy            (busy),
      .done            (done)
   );

   assign a_val  = reg_a[2:0];
   assign answer = x_bus[15:0];

   // Datapath buses and ALU; the y bus feeds B / 2B aligned onto the
   // accumulator field A[31:9].
   always_comb begin
      x_bus = 32'sd0;
      y_bus = 32'sd0;
      if (transfer[3])      x_bus = {{24{sw[7]}}, sw};
      else if (transfer[2]) x_bus = reg_c;
      else if (transfer[0]) x_bus = reg_a;
      if (transfer[1]) y_bus = (shl ? (reg_b <<< 1) : reg_b) <<< 9;
      case (alu)
         12'h001: z_bus = x_bus;
         12'h002: z_bus = {23'b0, x_bus[7:0], 1'b0};
         12'h004: z_bus = x_bus + y_bus;
         12'h008: z_bus = x_bus - y_bus;
         12'h010: z_bus = x_bus >>> 1;
         12'h020: z_bus = x_bus >>> 2;
         default: z_bus = 32'sd0;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (load[0]) reg_a <= z_bus;
      if (load[1]) reg_b <= z_bus;
      if (load[2]) reg_c <= z_bus;
   end

   // Monitor: a load must never coincide with a no-op ALU code.
   always_ff @(negedge clk) begin
      if (load != 3'b000 && alu == 12'h000) nop_load_viol <= nop_load_viol + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] outs();
      return {10'd0, transfer, load, alu, shl, busy, done};
   endfunction

   function automatic logic [31:0] pack(input logic [3:0] t, input logic [2:0] l,
                                        input logic [11:0] a, input logic s,
                                        input logic b, input logic d);
      return {10'd0, t, l, a, s, b, d};
   endfunction

   // One full multiply: mc * mp, optionally holding start high in WAIT_Q
   // for 'hold' cycles, optionally toggling start during ADD/SHIFT.
   task automatic do_mult(input logic [7:0] mc, input logic [7:0] mp,
                          input logic [15:0] exp_ans, input int hold,
                          input bit pulse, input string tag);
      int cycles;
      int add_bad;
      @(negedge clk);
      sw    = mc;
      start = 1'b1;
      @(negedge clk);
      check_val({tag, "_ldm"}, outs(), pack(4'b1000, 3'b010, 12'h001, 1'b0, 1'b1, 1'b0));
      if (hold == 0) start = 1'b0;
      @(negedge clk);
      check_val({tag, "_waitq"}, outs(), pack(4'b0000, 3'b000, 12'h000, 1'b0, 1'b1, 1'b0));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check_val({tag, "_hold"}, outs(), pack(4'b0000, 3'b000, 12'h000, 1'b0, 1'b1, 1'b0));
      end
      if (hold > 0) begin
         start = 1'b0;
         @(negedge clk);
         check_val({tag, "_waitq2"}, outs(), pack(4'b0000, 3'b000, 12'h000, 1'b0, 1'b1, 1'b0));
      end
      sw    = mp;
      start = 1'b1;
      @(negedge clk);
      check_val({tag, "_ldq"}, outs(), pack(4'b1000, 3'b001, 12'h002, 1'b0, 1'b1, 1'b0));
      start   = 1'b0;
      cycles  = 0;
      add_bad = 0;
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (transfer == 4'b0011 && (alu != 12'h000 || load != 3'b000)) add_bad++;
         if (pulse && cycles < 8) start = cycles[0];
         else start = 1'b0;
      end
      check_val({tag, "_latency"}, cycles, 32'd10);
      check_val({tag, "_answer"}, {16'd0, answer}, {16'd0, exp_ans});
      check_val({tag, "_done"}, outs(), pack(4'b0100, 3'b000, 12'h000, 1'b0, 1'b0, 1'b1));
      if (mp == 8'd0) check_val({tag, "_zero_add_nop"}, add_bad, 32'd0);
      @(negedge clk);
      check_val({tag, "_hold_c"}, {12'd0, transfer, answer}, {12'd0, 4'b0100, exp_ans});
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      sw    = 8'd0;
      // Reset held: start toggles must have no effect.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = ~start;
         #1;
         check_val("reset_outs", outs(), 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("idle_outs", outs(), 32'd0);
      end

      do_mult(8'd3,    8'd5,    16'h000F, 0, 1'b0, "m3x5");
      do_mult(8'hF9,   8'd6,    16'hFFD6, 0, 1'b0, "mn7x6");
      do_mult(8'h80,   8'h80,   16'h4000, 0, 1'b0, "mn128sq");
      do_mult(8'h7F,   8'h80,   16'hC080, 0, 1'b0, "m127xn128");
      do_mult(8'h37,   8'h00,   16'h0000, 0, 1'b0, "mq0");
      do_mult(8'd10,   8'hFD,   16'hFFE2, 3, 1'b0, "mhold");
      do_mult(8'd12,   8'd11,   16'h0084, 0, 1'b1, "mpulse");

      // Reset in the third SHIFT of a running multiply.
      @(negedge clk);
      sw    = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      sw    = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check_val("third_shift", outs(), pack(4'b0001, 3'b001, 12'h020, 1'b0, 1'b1, 1'b0));
      reset = 1'b1;
      #1;
      check_val("rst_now_outs", outs(), 32'd0);
      @(negedge clk);
      check_val("rst_idle_outs", outs(), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_idle", outs(), 32'd0);

      do_mult(8'd2, 8'd2, 16'h0004, 0, 1'b0, "m2x2");

      check_val("nop_load_viol", nop_load_viol, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
